// File: rtl/io_uart_responder_pkg.sv
// IO address map, status bit positions and serializer state encoding shared
// by the IO-bus responder and its UART serializer.
package io_map_pkg;

  // Address bit that selects IO space
  localparam int IO_SEL_BIT = 22;

  // Register offsets (addr[4:2])
  localparam logic [2:0] IO_LEDS  = 3'd0;
  localparam logic [2:0] IO_UDATA = 3'd1;
  localparam logic [2:0] IO_USTAT = 3'd2;
  localparam logic [2:0] IO_TIMER = 3'd3;

  // USTAT bit positions
  localparam int USTAT_BUSY    = 0;
  localparam int USTAT_FULL    = 1;
  localparam int USTAT_EMPTY   = 2;
  localparam int USTAT_OVF     = 3;
  localparam int USTAT_CNT_LSB = 8;

  // Serializer states
  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_e;

  // True when a byte address falls in IO space
  function automatic logic io_hit(input logic [31:0] addr);
    return addr[IO_SEL_BIT];
  endfunction

endpackage

// File: rtl/io_uart_responder_if.sv
// Core data-side IO port: address, write data, write strobe and read data.
interface io_uart_responder_if;
  logic [31:0] IO_mem_addr;
  logic [31:0] IO_mem_wdata;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_rdata;

  modport master (
    output IO_mem_addr,
    output IO_mem_wdata,
    output IO_mem_wr,
    input  IO_mem_rdata
  );

  modport slave (
    input  IO_mem_addr,
    input  IO_mem_wdata,
    input  IO_mem_wr,
    output IO_mem_rdata
  );
endinterface

// File: rtl/io_uart_responder_uart_tx_ser.sv
// UART 8N1 serializer: pops one byte from the TX FIFO when idle, then sends
// start bit, 8 data bits LSB first and a stop bit, each CLK_DIV cycles long.
module uart_tx_ser
  import io_map_pkg::*;
#(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       pop_o,
  output logic       txd_o,
  output logic       busy_o
);

  localparam int            BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);

  ser_state_e    state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          busy_q;

  // A byte is taken from the FIFO only in IDLE; the FSM leaves IDLE on the same edge
  assign pop_o  = (state_q == SER_IDLE) && valid_i;
  assign txd_o  = txd_q;
  assign busy_o = busy_q;

  // Frame sequencing, baud timing, shifting and registered line/busy outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SER_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        SER_IDLE: begin
          if (valid_i) begin
            shift_q <= data_i;
            baud_q  <= BAUD_LOAD;
            bit_q   <= 3'd0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SER_START;
          end
        end
        SER_START: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_LOAD;
            txd_q   <= shift_q[0];
            state_q <= SER_DATA;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        SER_DATA: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_LOAD;
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= SER_STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        SER_STOP: begin
          if (baud_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= SER_IDLE;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: begin
          state_q <= SER_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/io_uart_responder.sv
// IO-bus responder: LED register, UART TX FIFO + serializer, status register
// and (with IO_TIMER_EN defined) a free-running cycle timer at offset 3.
// Read data is combinational from the address because the core samples it in
// the same cycle it presents the address.
module io_uart_responder
  import io_map_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int LED_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  io_uart_responder_if.slave   bus,
  output logic [LED_W-1:0]     leds,
  output logic                 uart_txd,
  output logic                 uart_busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  // Decode
  logic       io_sel_s;
  logic [2:0] off_s;
  logic       wr_en_s;
  logic       push_req_s;
  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       pop_s;
  logic       ser_busy_s;
  logic       unused_s;

  assign io_sel_s   = io_hit(bus.IO_mem_addr);
  assign off_s      = bus.IO_mem_addr[4:2];
  assign wr_en_s    = bus.IO_mem_wr & io_sel_s;
  assign push_req_s = wr_en_s && (off_s == IO_UDATA);
  assign unused_s   = ^{bus.IO_mem_addr, bus.IO_mem_wdata};

  // State
  logic [LED_W-1:0] leds_q,   leds_d;
  logic             ovf_q,    ovf_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q,  count_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [31:0]      timer_s;
  logic [31:0]      rdata_s;

  // Fullness is judged on the registered count, so a push while full is dropped even if a pop happens
  assign full_s  = (count_q == CNTW'(FIFO_DEPTH));
  assign empty_s = (count_q == '0);
  assign push_s  = push_req_s & ~full_s;

  // Next-state for LEDs, overflow flag and FIFO pointers/count
  always_comb begin
    leds_d   = leds_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en_s && (off_s == IO_LEDS)) begin
      leds_d = bus.IO_mem_wdata[LED_W-1:0];
    end else begin
      leds_d = leds_q;
    end

    if (push_req_s && full_s) begin
      ovf_d = 1'b1;
    end else if (wr_en_s && (off_s == IO_USTAT) && bus.IO_mem_wdata[USTAT_OVF]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // Register update; reset flushes the FIFO by clearing pointers and count
  always_ff @(posedge clk) begin
    if (reset) begin
      leds_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      leds_q   <= leds_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset since empty is tracked by the count
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_q[wr_ptr_q] <= bus.IO_mem_wdata[7:0];
    end
  end

`ifdef IO_TIMER_EN
  logic [31:0] timer_q;

  // Free-running cycle counter; a write to TIMER restarts it from zero
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= 32'd0;
    end else if (wr_en_s && (off_s == IO_TIMER)) begin
      timer_q <= 32'd0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timer_s = timer_q;
`else
  assign timer_s = 32'd0;
`endif

  uart_tx_ser #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .valid_i (~empty_s),
    .data_i  (fifo_q[rd_ptr_q]),
    .pop_o   (pop_s),
    .txd_o   (uart_txd),
    .busy_o  (ser_busy_s)
  );

  // Zero-latency, side-effect-free read mux
  always_comb begin
    rdata_s = 32'd0;
    if (io_sel_s) begin
      case (off_s)
        IO_LEDS:  rdata_s = 32'(leds_q);
        IO_USTAT: begin
          rdata_s[USTAT_BUSY]                 = ser_busy_s;
          rdata_s[USTAT_FULL]                 = full_s;
          rdata_s[USTAT_EMPTY]                = empty_s;
          rdata_s[USTAT_OVF]                  = ovf_q;
          rdata_s[USTAT_CNT_LSB +: CNTW]      = count_q;
        end
        IO_TIMER: rdata_s = timer_s;
        default:  rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign bus.IO_mem_rdata = rdata_s;
  assign leds             = leds_q;
  assign uart_busy        = ser_busy_s;

endmodule

// File: tb/tb_io_uart_responder.sv
// Scoreboard bench for io_uart_responder (CLK_DIV=4, FIFO_DEPTH=4, LED_W=8).
// Stimulus pushes expectations into queues; a negedge monitor compares bus /
// pin values and a serial decoder reassembles frames from uart_txd.
module tb_io_uart_responder;

  localparam int CLK_DIV = 4;
  localparam logic [31:0] A_LEDS  = 32'h0040_0000;
  localparam logic [31:0] A_UDATA = 32'h0040_0004;
  localparam logic [31:0] A_USTAT = 32'h0040_0008;
  localparam logic [31:0] A_TIMER = 32'h0040_000C;
  localparam logic [31:0] A_UNMAP = 32'h0040_0014;

  localparam int K_RDATA = 0;
  localparam int K_LEDS  = 1;
  localparam int K_TXD   = 2;
  localparam int K_BUSY  = 3;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] leds;
  logic       uart_txd;
  logic       uart_busy;

  int checks   = 0;
  int failures = 0;

  exp_t       exp_q[$];
  logic [7:0] ser_exp[$];

  io_uart_responder_if bus();

  io_uart_responder #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (4),
    .LED_W      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .leds      (leds),
    .uart_txd  (uart_txd),
    .uart_busy (uart_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare every pending expectation against the DUT at the falling edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        K_RDATA: act = bus.IO_mem_rdata;
        K_LEDS:  act = 32'(leds);
        K_TXD:   act = 32'(uart_txd);
        default: act = 32'(uart_busy);
      endcase
      check(e.name, act, e.exp);
    end
  end

  // Serial decoder: detect start bit, sample mid-bit, compare bytes in order
  initial begin : ser_mon
    logic [7:0] b;
    logic [7:0] e;
    logic       abort;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (!reset && uart_txd === 1'b0) begin
        b = 8'd0;
        abort = 1'b0;
        stop_bit = 1'b0;
        for (int i = 1; i <= 38 && !abort; i++) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
          else if (i >= 6 && i <= 34 && (i % 4) == 2) b[(i - 6) / 4] = uart_txd;
          else if (i == 38) stop_bit = uart_txd;
        end
        if (!abort) begin
          check("ser_stop_bit", 32'(stop_bit), 32'd1);
          if (ser_exp.size() == 0) begin
            check("ser_unexpected_frame", 32'(b), 32'hFFFF_FFFF);
          end else begin
            e = ser_exp.pop_front();
            check("ser_byte", 32'(b), 32'(e));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    bus.IO_mem_addr = addr;
    bus.IO_mem_wr   = 1'b0;
    expect_sig(K_RDATA, exp, name);
    tick();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.IO_mem_addr  = addr;
    bus.IO_mem_wdata = data;
    bus.IO_mem_wr    = 1'b1;
    tick();
    bus.IO_mem_wr    = 1'b0;
  endtask

  initial begin
    logic [7:0] b55;
    logic       exp_bit;
    int         p;

    bus.IO_mem_addr  = 32'd0;
    bus.IO_mem_wdata = 32'd0;
    bus.IO_mem_wr    = 1'b0;

    // 1: reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    expect_sig(K_LEDS, 32'h0, "reset_leds");
    expect_sig(K_TXD,  32'h1, "reset_txd");
    expect_sig(K_BUSY, 32'h0, "reset_busy");
    rd(A_USTAT, 32'h0000_0004, "reset_ustat");

    // 2: single byte 0x55, cycle-exact line and busy
    b55 = 8'h55;
    ser_exp.push_back(8'h55);
    wr(A_UDATA, 32'h0000_0055);
    expect_sig(K_TXD, 32'h1, "t2_txd_before_pop");
    rd(A_USTAT, 32'h0000_0100, "t2_ustat_queued");
    for (int i = 0; i < 40; i++) begin
      p = i / 4;
      if (p == 0) exp_bit = 1'b0;
      else if (p == 9) exp_bit = 1'b1;
      else exp_bit = b55[p - 1];
      expect_sig(K_TXD,  32'(exp_bit), "t2_txd_bit");
      expect_sig(K_BUSY, 32'h1,        "t2_busy_high");
      tick();
    end
    expect_sig(K_BUSY, 32'h0, "t2_busy_low_after");
    expect_sig(K_TXD,  32'h1, "t2_txd_idle_after");
    rd(A_USTAT, 32'h0000_0004, "t2_ustat_done");

    // 3: overflow on sixth back-to-back push
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) ser_exp.push_back(8'(i));
      wr(A_UDATA, 32'(i));
    end
    rd(A_USTAT, 32'h0000_040B, "t3_ustat_overflow");
    wr(A_USTAT, 32'h0000_0008);
    rd(A_USTAT, 32'h0000_0403, "t3_ustat_ovf_cleared");
    repeat (220) tick();
    rd(A_USTAT, 32'h0000_0004, "t3_ustat_drained");
    check("t3_all_frames_seen", 32'(ser_exp.size()), 32'd0);

    // 4: LED register and IO select
    wr(A_LEDS, 32'h0000_00A5);
    expect_sig(K_LEDS, 32'h0000_00A5, "t4_leds_pin");
    rd(A_LEDS, 32'h0000_00A5, "t4_leds_read");
    wr(32'h0000_0000, 32'h0000_003C);
    expect_sig(K_LEDS, 32'h0000_00A5, "t4_leds_non_io_write");
    rd(32'h0000_0000, 32'h0000_0000, "t4_non_io_read");
    rd(A_UDATA, 32'h0000_0000, "t4_udata_reads_zero");
    wr(A_UNMAP, 32'hFFFF_FFFF);
    rd(A_UNMAP, 32'h0000_0000, "t4_unmapped_read");
    rd(A_LEDS, 32'h0000_00A5, "t4_leds_after_unmapped");

    // 5: reset during DATA bit 3 with two bytes queued
    ser_exp.push_back(8'h33);
    wr(A_UDATA, 32'h0000_0033);
    wr(A_UDATA, 32'h0000_0044);
    wr(A_UDATA, 32'h0000_0066);
    repeat (15) tick();
    expect_sig(K_TXD,  32'h0, "t5_txd_bit3");
    expect_sig(K_BUSY, 32'h1, "t5_busy_mid_frame");
    rd(A_USTAT, 32'h0000_0201, "t5_ustat_two_queued");
    reset = 1'b1;
    ser_exp.delete();
    tick();
    reset = 1'b0;
    expect_sig(K_TXD,  32'h1, "t5_txd_after_reset");
    expect_sig(K_BUSY, 32'h0, "t5_busy_after_reset");
    expect_sig(K_LEDS, 32'h0, "t5_leds_after_reset");
    rd(A_USTAT, 32'h0000_0004, "t5_ustat_after_reset");
    for (int i = 0; i < 60; i++) begin
      expect_sig(K_TXD, 32'h1, "t5_no_frame");
      tick();
    end

    // 6: timer
`ifdef IO_TIMER_EN
    wr(A_TIMER, 32'h1234_5678);
    rd(A_TIMER, 32'd0, "t6_timer_after_write");
    repeat (9) tick();
    rd(A_TIMER, 32'd10, "t6_timer_plus_10");
`else
    rd(A_TIMER, 32'd0, "t6_timer_absent");
    wr(A_TIMER, 32'h1234_5678);
    rd(A_TIMER, 32'd0, "t6_timer_absent_after_write");
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
